plab4_net_inject_sched: RTL
===========================

# plab4_net_inject_sched

Injection scheduler that shares one ring-network terminal input port among `p_num_reqs` local requesters. Each requester presents a val/rdy stream of full network messages. The block selects one requester per cycle, captures the message into a single-entry output buffer, and presents it on the network injection port. It sits between the tile-side message sources and one `in_val/in_rdy/in_msg` port of the ring network. Arbitration is either work-conserving round-robin or strict time-division (TDMA) for timing-channel isolation.

## Interface

Parameters:
- `p_num_reqs`, 4: number of requesters, ≥2.
- `p_payload_nbits`, 32: message payload width.
- `p_opaque_nbits`, 3: message opaque width.
- `p_srcdest_nbits`, 3: message src/dest width.
- `p_slot_cycles`, 4: TDMA slot length in cycles, ≥2. Ignored in round-robin mode.
- `c_net_msg_nbits`, `VC_NET_MSG_NBITS(p,o,s)`: message width M. Derived; not set externally.
- `c_id_nbits`, `$clog2(p_num_reqs)`: requester-index width. Derived.

Ports:
- `clk`  in  1  clock.
- `reset_n`  in  1  reset. Single clock; reset is asynchronous and active-low.
- `req_val`  in  `p_num_reqs`  per-requester valid.
- `req_rdy`  out  `p_num_reqs`  per-requester ready.
- `req_msg`  in  `p_num_reqs*M`  requester i occupies bits `[i*M +: M]`.
- `net_val`  out  1  buffered message valid.
- `net_rdy`  in  1  network port ready.
- `net_msg`  out  M  buffered message.
- `net_id`  out  `c_id_nbits`  index of the requester whose message is in the buffer.
- `slot_owner`  out  `c_id_nbits`  current TDMA owner. In round-robin mode, this is the round-robin pointer.

## Operation

- Output buffer: one entry made of `full`, `msg` and `id`.
  - `net_val = full`.
  - `net_msg` and `net_id` come straight from the registers.
- Accept condition: `can_accept = !full || net_rdy`. Dequeue and enqueue in the same cycle are allowed.
- The selected requester `sel` is computed combinationally.
  - `req_rdy[i] = can_accept && eligible && (i == sel)`.
  - Every other `req_rdy` bit is 0.
  - `req_rdy` does not depend on `req_val[i]` of the same requester, except through selection in round-robin mode.
- Transfer occurs when `req_val[sel] && req_rdy[sel]`. Buffer then loads `msg = req_msg[sel]`, `id = sel`, `full = 1`.
- On dequeue (`net_val && net_rdy`) with no enqueue in the same cycle, `full` goes to 0.
- Round-robin mode:
  - Pointer `ptr` resets to 0.
  - `sel` is the first i with `req_val[i]=1`, scanning `ptr, ptr+1, …` modulo `p_num_reqs`.
  - `eligible` = any `req_val`.
  - After each transfer, `ptr` ← `(sel+1) mod p_num_reqs`. Without a transfer, `ptr` holds.
- TDMA mode:
  - Slot counter `cnt` runs 0…`p_slot_cycles-1` every cycle, independent of traffic.
  - On wrap, `owner` ← `(owner+1) mod p_num_reqs`.
  - `sel = owner`.
  - `eligible = (cnt != p_slot_cycles-1)`. The last cycle of each slot is a guard cycle with no accepts.
  - A message still buffered at a slot change drains normally. The new owner is blocked only by `can_accept`.
- Reset, asynchronous on `reset_n` low:
  - `full=0`, so `net_val=0`; `net_msg=0`; `net_id=0`.
  - `ptr=0`, `cnt=0`, `owner=0`, so `slot_owner=0`.
  - All `req_rdy=0` while `reset_n` is low.
  - A buffered message is discarded. A requester mid-handshake sees no transfer.

## Timing

- Latency: a message accepted at edge t is visible on `net_val` and `net_msg` in the cycle after t.
- Round-robin throughput: 1 message/cycle with `net_rdy` held high.
- TDMA throughput: at most `p_slot_cycles-1` messages per `p_slot_cycles` cycles, owner only.
- `net_val` never deasserts without a dequeue. `net_msg` is stable while `net_val && !net_rdy`.
- Net backpressure: `full && !net_rdy` forces all `req_rdy=0` and freezes `ptr`.
- TDMA slot boundary: the owner changes on the edge after `cnt = p_slot_cycles-1`. `slot_owner` reflects the new owner in that cycle.
- `p_num_reqs` not a power of two: `ptr` and `owner` wrap explicitly at `p_num_reqs-1` and never hold an illegal index.

## Configuration

- Macro: `PLAB4_NET_INJECT_SCHED_TDMA_EN`.
  - Defined: TDMA mode as above. The round-robin pointer is not built, and `slot_owner` shows `owner`.
  - Undefined: round-robin mode. The slot counter is not built, `p_slot_cycles` is unused, and `slot_owner` shows `ptr`.

## Test plan

- Reset, then reset deasserted with all `req_val=0` → `net_val=0`, `req_rdy=0`, `slot_owner=0`. Assert `reset_n` low mid-transfer with `full=1` → `net_val=0` immediately.
- Round-robin: all 4 requesters valid, `net_rdy=1` → `net_id` sequence 0,1,2,3,0…, one message per cycle, each `msg` matches its source.
- Round-robin: `net_rdy=0` for 3 cycles with the buffer full → `req_rdy=0`, `net_msg` stable, `ptr` unchanged. Releasing `net_rdy` yields dequeue plus enqueue in the same cycle.
- Round-robin: only requesters 1 and 3 valid, with `ptr=2` → grant order 3,1,3.
- TDMA with `p_slot_cycles=4`, only requester 2 valid → accepts only in cycles 8,9,10 of every 16-cycle frame. `req_rdy[2]=0` in guard cycle 11 and in other slots.
- TDMA: a message accepted at `cnt=2` of slot 0 with `net_rdy=0` through the slot change → the message stays on `net_msg` with `net_id=0`, and requester 1's first accept comes only in the cycle `net_rdy` returns high.

Source files
------------

// File: rtl/plab4_net_inject_sched.sv
// Shares one ring-network injection port among p_num_reqs requesters through a one-entry buffer.
// Define PLAB4_NET_INJECT_SCHED_TDMA_EN for TDMA slots; round-robin arbitration otherwise.
module plab4_net_inject_sched #(
  parameter int unsigned p_num_reqs      = 4,
  parameter int unsigned p_payload_nbits = 32,
  parameter int unsigned p_opaque_nbits  = 3,
  parameter int unsigned p_srcdest_nbits = 3,
  parameter int unsigned p_slot_cycles   = 4,
  localparam int unsigned c_net_msg_nbits =
    p_payload_nbits + p_opaque_nbits + 2 * p_srcdest_nbits,
  localparam int unsigned c_id_nbits = $clog2(p_num_reqs)
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic [p_num_reqs-1:0]                 req_val,
  output logic [p_num_reqs-1:0]                 req_rdy,
  input  logic [p_num_reqs*c_net_msg_nbits-1:0] req_msg,
  output logic                                  net_val,
  input  logic                                  net_rdy,
  output logic [c_net_msg_nbits-1:0]            net_msg,
  output logic [c_id_nbits-1:0]                 net_id,
  output logic [c_id_nbits-1:0]                 slot_owner
);

  if (p_num_reqs < 2 || p_slot_cycles < 2) begin : g_bad_cfg
    $error("plab4_net_inject_sched: p_num_reqs and p_slot_cycles must be at least 2");
  end

  logic                       full_q, full_d;
  logic [c_net_msg_nbits-1:0] msg_q, msg_d;
  logic [c_id_nbits-1:0]      id_q, id_d;

  logic [c_id_nbits-1:0]      sel;
  logic                       eligible;
  logic                       can_accept;
  logic                       xfer;
  logic                       deq;

`ifdef PLAB4_NET_INJECT_SCHED_TDMA_EN
  localparam int unsigned c_cnt_nbits = $clog2(p_slot_cycles);

  logic [c_cnt_nbits-1:0] cnt_q, cnt_d;
  logic [c_id_nbits-1:0]  owner_q, owner_d;
  logic                   slot_last;

  // Last cycle of every slot is a guard cycle: nothing is accepted.
  assign slot_last = (cnt_q == c_cnt_nbits'(p_slot_cycles - 1));

  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    owner_d = owner_q;
    if (slot_last) begin
      cnt_d   = '0;
      owner_d = (owner_q == c_id_nbits'(p_num_reqs - 1)) ? '0 : owner_q + 1'b1;
    end
  end

  assign sel        = owner_q;
  assign eligible   = !slot_last;
  assign slot_owner = owner_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      owner_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
    end
  end
`else
  logic [c_id_nbits-1:0] ptr_q, ptr_d;
  logic [c_id_nbits:0]   scan;

  // Scan ptr, ptr+1, ... with an explicit wrap so non-power-of-two counts stay legal.
  always_comb begin
    sel      = ptr_q;
    eligible = 1'b0;
    scan     = '0;
    for (int k = 0; k < int'(p_num_reqs); k++) begin
      scan = {1'b0, ptr_q} + (c_id_nbits + 1)'(k);
      if (scan >= (c_id_nbits + 1)'(p_num_reqs)) begin
        scan = scan - (c_id_nbits + 1)'(p_num_reqs);
      end
      if (!eligible && req_val[scan[c_id_nbits-1:0]]) begin
        eligible = 1'b1;
        sel      = scan[c_id_nbits-1:0];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (xfer) begin
      ptr_d = (sel == c_id_nbits'(p_num_reqs - 1)) ? '0 : sel + 1'b1;
    end
  end

  assign slot_owner = ptr_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  assign can_accept = !full_q || net_rdy;
  assign deq        = full_q && net_rdy;

  // Gated by reset_n so no requester sees a handshake while reset is held.
  always_comb begin
    req_rdy = '0;
    if (reset_n && can_accept && eligible) begin
      req_rdy[sel] = 1'b1;
    end
  end

  assign xfer = req_val[sel] && req_rdy[sel];

  always_comb begin
    full_d = full_q;
    msg_d  = msg_q;
    id_d   = id_q;
    if (xfer) begin
      full_d = 1'b1;
      msg_d  = req_msg[sel * c_net_msg_nbits +: c_net_msg_nbits];
      id_d   = sel;
    end else if (deq) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      full_q <= 1'b0;
      msg_q  <= '0;
      id_q   <= '0;
    end else begin
      full_q <= full_d;
      msg_q  <= msg_d;
      id_q   <= id_d;
    end
  end

  assign net_val = full_q;
  assign net_msg = msg_q;
  assign net_id  = id_q;

endmodule
